// File: rtl/tt_um_uabc_char_seq_if.sv
// -----------------------------------------------------------------------------
// tt_um_uabc_char_seq_if
// Groups the pin-level bus of the character sequencer so a host model can
// drive it as one bundle.
//   ena     : power-good, always 1 (ignored by the design)
//   ui_in   : [0] run, [1] dir, [2] step, [3] wr, [7:4] wr_addr
//   uio_in  : table write data
//   uo_out  : registered ASCII code of the current entry
//   uio_out : constant 0
//   uio_oe  : constant 0 (all uio pins are inputs)
// Modports:
//   master : host side, drives the inputs and observes the outputs
//   slave  : sequencer side
// Handshake: there is no valid/ready pair. step and wr are level pins whose
// rising edges are the transfer events; wr_addr/uio_in must be held stable
// for at least 4 cycles around the wr rising edge.
// -----------------------------------------------------------------------------
interface tt_um_uabc_char_seq_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_uabc_char_seq.sv
// -----------------------------------------------------------------------------
// tt_um_uabc_char_seq
// Steps through a small writable table of ASCII characters and shows the
// current entry on uo_out. It advances automatically every TICK_CYCLES
// clocks while run is high, or once per step edge while run is low.
// Parameters:
//   TICK_CYCLES : clocks per automatic step (>= 2)
//   DEPTH       : table entries, power of two, 2..16
// Ports:
//   clk     : clock, all state on rising edge
//   rst_n   : asynchronous active-low reset
//   ena     : ignored
//   ui_in   : [0] run, [1] dir (0 up / 1 down), [2] step, [3] wr, [7:4] wr_addr
//   uio_in  : table write data
//   uo_out  : registered table[idx]
//   uio_out : constant 8'h00
//   uio_oe  : constant 8'h00
// There is no FSM; the observable state is idx, the prescaler and the table.
// -----------------------------------------------------------------------------
module tt_um_uabc_char_seq #(
  parameter int TICK_CYCLES = 25_000_000,
  parameter int DEPTH       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

  // Reset contents: 'A'..'F' then '0'..'9'.
  function automatic logic [7:0] init_char(input int i);
    if (i < 6) return 8'(32'h41 + i);
    else       return 8'(32'h30 + i - 6);
  endfunction

  logic          run;
  logic          dir;
  logic [IW-1:0] wr_addr;

  assign run     = ui_in[0];
  assign dir     = ui_in[1];
  assign wr_addr = ui_in[4 +: IW];

  // ena and any wr_addr bits above IW carry no information.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:4]};

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // ---------------------------------------------------------------------------
  // Prescaler: free-runs only while run is high, held at 0 otherwise, so the
  // first tick after run rises is always a full TICK_CYCLES away.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = run && (presc == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!run || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // step / wr: two-flop synchroniser plus an edge flop; the pulse is one
  // cycle wide and fires once per rising edge regardless of hold time.
  // ---------------------------------------------------------------------------
  logic step_s1, step_s2, step_d;
  logic wr_s1, wr_s2, wr_d;
  logic step_pulse, wr_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_d  <= 1'b0;
      wr_s1   <= 1'b0;
      wr_s2   <= 1'b0;
      wr_d    <= 1'b0;
    end else begin
      step_s1 <= ui_in[2];
      step_s2 <= step_s1;
      step_d  <= step_s2;
      wr_s1   <= ui_in[3];
      wr_s2   <= wr_s1;
      wr_d    <= wr_s2;
    end
  end

  assign step_pulse = step_s2 & ~step_d;
  assign wr_pulse   = wr_s2 & ~wr_d;

  // ---------------------------------------------------------------------------
  // Index: manual steps only count while stopped. DEPTH is a power of two,
  // so natural IW-bit overflow gives the modulo-DEPTH wrap in both directions.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] idx;
  logic          advance;

  assign advance = tick | (step_pulse & ~run);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (advance) begin
      idx <= dir ? (idx - IW'(1)) : (idx + IW'(1));
    end
  end

  // ---------------------------------------------------------------------------
  // Character table. Address and data are sampled raw in the pulse cycle;
  // the host keeps them stable across the synchroniser delay.
  // ---------------------------------------------------------------------------
  logic [7:0] char_tab [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        char_tab[i] <= init_char(i);
      end
    end else if (wr_pulse) begin
      char_tab[wr_addr] <= uio_in;
    end
  end

  // Output register: follows idx and table changes one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_out <= 8'h41;
    end else begin
      uo_out <= char_tab[idx];
    end
  end

endmodule

// File: tb/tb_tt_um_uabc_char_seq.sv
module tb_tt_um_uabc_char_seq;

  logic clk = 1'b0;
  logic rst_n;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  tt_um_uabc_char_seq_if bus ();

  logic       run, dir, step, wr;
  logic [3:0] addr;

  assign bus.ena   = 1'b1;
  assign bus.ui_in = {addr, wr, step, dir, run};

  tt_um_uabc_char_seq #(
    .TICK_CYCLES(4),
    .DEPTH      (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (bus.ena),
    .ui_in  (bus.ui_in),
    .uio_in (bus.uio_in),
    .uo_out (bus.uo_out),
    .uio_out(bus.uio_out),
    .uio_oe (bus.uio_oe)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: expected display changes with the hold length of the value
  // they replace (0 = hold not checked).
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         len_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: every change of uo_out outside reset must match the next entry.
  logic [7:0] prev_out;
  int         run_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_out = bus.uo_out;
      run_len  = 0;
    end else if (bus.uo_out !== prev_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", bus.uo_out, prev_out);
      end else begin
        logic [7:0] e;
        int         l;
        e = exp_q.pop_front();
        l = len_q.pop_front();
        check("seq_value", bus.uo_out, e);
        if (l != 0) check_int("hold_len", run_len, l);
      end
      prev_out = bus.uo_out;
      run_len  = 1;
    end else begin
      run_len++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] v, input int l);
    exp_q.push_back(v);
    len_q.push_back(l);
  endtask

  task automatic drain(input string tag, input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_int(tag, exp_q.size(), 0);
    exp_q.delete();
    len_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    dir   = 1'b0;
    step  = 1'b0;
    wr    = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cycles(3);
    step = 1'b0;
    cycles(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] up_seq [16];
    for (int i = 0; i < 5; i++)  up_seq[i] = 8'(8'h42 + i);
    for (int i = 5; i < 15; i++) up_seq[i] = 8'(8'h30 + i - 5);
    up_seq[15] = 8'h41;

    rst_n = 1'b1;
    run = 0; dir = 0; step = 0; wr = 0; addr = 0;
    bus.uio_in = 8'h00;
    #1;
    rst_n = 1'b0;
    run  = 1'($urandom_range(0, 1));
    dir  = 1'($urandom_range(0, 1));
    step = 1'($urandom_range(0, 1));
    wr   = 1'($urandom_range(0, 1));
    addr = 4'($urandom_range(0, 15));
    bus.uio_in = 8'($urandom_range(0, 255));
    #1;
    check("reset_uo_out", bus.uo_out, 8'h41);
    check("reset_uio_out", bus.uio_out, 8'h00);
    check("reset_uio_oe", bus.uio_oe, 8'h00);
    run = 0; dir = 0; step = 0; wr = 0; addr = 0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // Free run upward through the whole table and back to 'A'.
    for (int i = 0; i < 16; i++) push(up_seq[i], (i == 0) ? 0 : 4);
    run = 1'b1;
    cycles(4);
    check("first_tick_not_early", bus.uo_out, 8'h41);
    drain("run_up_drain", 90);
    run = 1'b0;
    cycles(6);

    // Free run downward, then reverse mid-period.
    do_reset();
    push(8'h39, 0); push(8'h38, 4); push(8'h37, 4);
    dir = 1'b1;
    run = 1'b1;
    drain("run_down_drain", 40);
    cycles(1);
    dir = 1'b0;
    push(8'h38, 4); push(8'h39, 4);
    drain("dir_flip_drain", 20);
    run = 1'b0;
    cycles(6);
    check("stopped_after_flip", bus.uo_out, 8'h39);

    // Manual stepping.
    do_reset();
    push(8'h42, 0); push(8'h43, 0); push(8'h44, 0);
    repeat (3) pulse_step();
    drain("step_drain", 10);
    check("three_steps", bus.uo_out, 8'h44);

    // Step while running is ignored; only ticks advance.
    push(8'h45, 0); push(8'h46, 4);
    run  = 1'b1;
    step = 1'b1;
    cycles(3);
    step = 1'b0;
    drain("step_while_run_drain", 20);
    run = 1'b0;
    cycles(8);
    check("step_while_run", bus.uo_out, 8'h46);

    // Step held high gives a single advance.
    push(8'h30, 0);
    step = 1'b1;
    cycles(20);
    step = 1'b0;
    cycles(6);
    drain("step_held_drain", 5);
    check("step_held", bus.uo_out, 8'h30);

    // Table write off-screen, then step onto it.
    do_reset();
    addr = 4'd2;
    bus.uio_in = 8'h5A;
    cycles(1);
    wr = 1'b1;
    cycles(6);
    wr = 1'b0;
    cycles(4);
    push(8'h42, 0); push(8'h5A, 0);
    repeat (2) pulse_step();
    drain("write_step_drain", 10);
    check("written_entry", bus.uo_out, 8'h5A);

    // Write to the displayed entry shows up within 5 cycles.
    bus.uio_in = 8'h21;
    cycles(1);
    push(8'h21, 0);
    wr = 1'b1;
    drain("write_displayed_latency", 5);
    cycles(3);
    wr = 1'b0;
    cycles(4);
    check("write_displayed", bus.uo_out, 8'h21);

    // Reset in the middle of a run discards writes and position.
    push(8'h44, 0); push(8'h45, 4);
    run = 1'b1;
    drain("pre_reset_run_drain", 20);
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    check("mid_run_reset", bus.uo_out, 8'h41);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    push(8'h42, 0); push(8'h43, 0);
    repeat (2) pulse_step();
    drain("post_reset_step_drain", 10);
    check("post_reset_entry2", bus.uo_out, 8'h43);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
